// File: rtl/simple_uart_rx.sv
// 8N1 UART receiver with a small receive FIFO and a four-register bus slave.
// The frame timer is loaded from BSR at start detection, so BSR writes only affect later frames.
`timescale 1ns/1ps
module simple_uart_rx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rxd_i,
  input  logic        sel_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        we_i,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

  state_t        state;
  logic          rxd_s1, rxd_s2, rxd_prev;
  logic [33:0]   timer, period;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [31:0]   bsr;
  logic          cr_en, ovr, fe;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;

  logic          rd_acc, wr_sr, wr_bsr, wr_cr, abort;
  logic          empty, full, pop, expired;
  logic          push_req, push, ovr_set, fe_set, cr_en_n;
  logic [33:0]   per_calc;
  logic [4:0]    count_w;
  logic [2:0]    cnt3;
  logic [31:0]   sr_val, rd_mux;

  always_comb begin
    rd_acc   = sel_i && !we_i;
    wr_sr    = sel_i && we_i && (addr_i == 2'd1);
    wr_bsr   = sel_i && we_i && (addr_i == 2'd2);
    wr_cr    = sel_i && we_i && (addr_i == 2'd3);
    abort    = wr_cr && !data_i[0];
    empty    = (count == '0);
    full     = (count == CW'(FIFO_DEPTH));
    pop      = rd_acc && (addr_i == 2'd0) && !empty;
    expired  = (timer <= 34'd1);
    push_req = (state == S_STOP) && expired && rxd_s2 && !abort;
    fe_set   = (state == S_STOP) && expired && !rxd_s2 && !abort;
    push     = push_req && (!full || pop);
    ovr_set  = push_req && full && !pop;
    count_n  = count + CW'(push) - CW'(pop);
    cr_en_n  = wr_cr ? data_i[0] : cr_en;
    // 3*(BSR+1) without a multiplier
    per_calc = {2'b00, bsr} + {1'b0, bsr, 1'b0} + 34'd3;
    count_w  = 5'(count);
    cnt3     = (count_w > 5'd7) ? 3'd7 : count_w[2:0];
    sr_val   = {24'b0, (state != S_IDLE), cnt3, fe, ovr, full, !empty};
    rd_mux   = '0;
    case (addr_i)
      2'd0: rd_mux = empty ? '0 : {24'b0, mem[rd_ptr]};
      2'd1: rd_mux = sr_val;
      2'd2: rd_mux = bsr;
      default: rd_mux = {31'b0, cr_en};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      state    <= S_IDLE;
      timer    <= '0;
      period   <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      rxd_s1   <= rxd_i;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      if (abort) begin
        state <= S_IDLE;
        timer <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cr_en && rxd_prev && !rxd_s2) begin
              state  <= S_START;
              period <= per_calc;
              timer  <= per_calc >> 1;
            end
          end
          S_START: begin
            if (expired) begin
              if (!rxd_s2) begin
                state   <= S_DATA;
                timer   <= period;
                bit_cnt <= '0;
              end else begin
                state <= S_IDLE;
                timer <= '0;
              end
            end else begin
              timer <= timer - 34'd1;
            end
          end
          S_DATA: begin
            if (expired) begin
              shift <= {rxd_s2, shift[7:1]};
              timer <= period;
              if (bit_cnt == 3'd7) state <= S_STOP;
              else bit_cnt <= bit_cnt + 3'd1;
            end else begin
              timer <= timer - 34'd1;
            end
          end
          S_STOP: begin
            if (expired) begin
              state <= rxd_s2 ? S_IDLE : S_WAIT_HIGH;
              timer <= '0;
            end else begin
              timer <= timer - 34'd1;
            end
          end
          S_WAIT_HIGH: begin
            if (rxd_s2) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      bsr    <= 32'd2;
      cr_en  <= 1'b1;
      ovr    <= 1'b0;
      fe     <= 1'b0;
      data_o <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      if (wr_bsr) bsr <= data_i;
      cr_en <= cr_en_n;
      // set has priority over write-1-clear
      ovr <= ovr_set || (ovr && !(wr_sr && data_i[2]));
      fe  <= fe_set  || (fe  && !(wr_sr && data_i[3]));
      if (rd_acc) data_o <= rd_mux;
      irq_o <= cr_en_n && (count_n != '0);
    end
  end

endmodule

// File: tb/tb_simple_uart_rx.sv
// Directed bench for simple_uart_rx: table of single frames plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_simple_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        rxd_i = 1'b1;
  logic        sel_i = 1'b0;
  logic [1:0]  addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        we_i = 1'b0;
  logic        irq_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  simple_uart_rx #(.FIFO_DEPTH(4)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rxd_i  (rxd_i),
    .sel_i  (sel_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .we_i   (we_i),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_i);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk_i);
    sel_i = 1'b0; we_i = 1'b0; data_i = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk_i);
    sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    sel_i = 1'b0;
    d = data_o;
  endtask

  task automatic send_frame(input logic [7:0] b, input int cpb, input int stop_low);
    @(posedge clk_i); #1;
    rxd_i = 1'b0;
    repeat (cpb) @(posedge clk_i); #1;
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      repeat (cpb) @(posedge clk_i); #1;
    end
    if (stop_low > 0) begin
      rxd_i = 1'b0;
      repeat (cpb * stop_low) @(posedge clk_i); #1;
    end
    rxd_i = 1'b1;
    repeat (cpb) @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic [31:0] bsr;
    int          cpb;
    logic [7:0]  tx;
    logic [31:0] exp_sr_full;
    logic [31:0] exp_rdr;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] rd;

  initial begin
    vecs[0] = '{32'd2, 9,  8'hA5, 32'h11, 32'h0000_00A5};
    vecs[1] = '{32'd2, 9,  8'h00, 32'h11, 32'h0000_0000};
    vecs[2] = '{32'd2, 9,  8'hFF, 32'h11, 32'h0000_00FF};
    vecs[3] = '{32'd0, 3,  8'h3C, 32'h11, 32'h0000_003C};
    vecs[4] = '{32'd1, 6,  8'h81, 32'h11, 32'h0000_0081};
    vecs[5] = '{32'd3, 12, 8'h5A, 32'h11, 32'h0000_005A};

    // reset values
    #1;
    check("rst_data_o", data_o, 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'h0);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    bus_read(2'd1, rd); check("rst_sr", rd, 32'h0);
    bus_read(2'd2, rd); check("rst_bsr", rd, 32'd2);
    bus_read(2'd3, rd); check("rst_cr", rd, 32'd1);

    // single frames at several bit rates
    for (int v = 0; v < 6; v++) begin
      bus_write(2'd2, vecs[v].bsr);
      send_frame(vecs[v].tx, vecs[v].cpb, 0);
      repeat (2) @(posedge clk_i);
      check($sformatf("vec%0d_irq", v), {31'b0, irq_o}, 32'h1);
      bus_read(2'd1, rd); check($sformatf("vec%0d_sr", v), rd, vecs[v].exp_sr_full);
      bus_read(2'd0, rd); check($sformatf("vec%0d_rdr", v), rd, vecs[v].exp_rdr);
      bus_read(2'd1, rd); check($sformatf("vec%0d_sr_after", v), rd, 32'h0);
      check($sformatf("vec%0d_irq_after", v), {31'b0, irq_o}, 32'h0);
    end
    bus_write(2'd2, 32'd2);

    // writes to RDR are ignored and data_o holds
    bus_read(2'd2, rd); check("bsr_restore", rd, 32'd2);
    bus_write(2'd0, 32'hDEAD_BEEF);
    @(negedge clk_i);
    check("rdr_write_hold", data_o, 32'd2);

    // overflow: 5 frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 9, 0);
    repeat (2) @(posedge clk_i);
    check("ovr_irq", {31'b0, irq_o}, 32'h1);
    bus_read(2'd1, rd); check("ovr_sr", rd, 32'h47);
    for (int i = 1; i <= 4; i++) begin
      bus_read(2'd0, rd); check($sformatf("ovr_rdr%0d", i), rd, 32'(i));
    end
    bus_read(2'd0, rd); check("ovr_rdr_empty", rd, 32'h0);
    bus_read(2'd1, rd); check("ovr_sr_after", rd, 32'h04);
    bus_write(2'd1, 32'h04);
    bus_read(2'd1, rd); check("ovr_cleared", rd, 32'h0);

    // framing error with stop held low for 3 bit times
    fork
      send_frame(8'h3C, 9, 3);
      begin
        repeat (96) @(posedge clk_i);
        bus_read(2'd1, rd); check("fe_sr_busy", rd, 32'h88);
      end
    join
    repeat (3) @(posedge clk_i);
    bus_read(2'd1, rd); check("fe_sr_idle", rd, 32'h08);
    check("fe_irq", {31'b0, irq_o}, 32'h0);
    bus_write(2'd1, 32'h08);
    bus_read(2'd1, rd); check("fe_cleared", rd, 32'h0);

    // 3-clock glitch is rejected in START
    @(posedge clk_i); #1 rxd_i = 1'b0;
    repeat (3) @(posedge clk_i); #1 rxd_i = 1'b1;
    repeat (20) @(posedge clk_i);
    bus_read(2'd1, rd); check("glitch_sr", rd, 32'h0);
    check("glitch_irq", {31'b0, irq_o}, 32'h0);

    // disabling mid-frame aborts without a push
    fork
      send_frame(8'h77, 9, 0);
      begin
        repeat (30) @(posedge clk_i);
        bus_write(2'd3, 32'h0);
      end
    join
    repeat (3) @(posedge clk_i);
    bus_read(2'd1, rd); check("abort_sr", rd, 32'h0);
    bus_read(2'd3, rd); check("abort_cr", rd, 32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd); check("reenable_cr", rd, 32'h1);

    // reset during data bit 4
    send_frame(8'h11, 9, 0);
    repeat (2) @(posedge clk_i);
    bus_read(2'd1, rd); check("pre_rst_sr", rd, 32'h11);
    check("pre_rst_irq", {31'b0, irq_o}, 32'h1);
    @(posedge clk_i); #1 rxd_i = 1'b0;
    repeat (9) @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) begin
      rxd_i = (i == 1 || i == 3);
      repeat (9) @(posedge clk_i); #1;
    end
    rxd_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_data_o", data_o, 32'h0);
    check("midrst_irq", {31'b0, irq_o}, 32'h0);
    repeat (5) @(posedge clk_i);
    #3 rst_i = 1'b1;
    repeat (5) @(posedge clk_i);
    bus_read(2'd1, rd); check("postrst_sr", rd, 32'h0);
    bus_read(2'd2, rd); check("postrst_bsr", rd, 32'd2);
    send_frame(8'h5A, 9, 0);
    repeat (2) @(posedge clk_i);
    bus_read(2'd0, rd); check("postrst_rdr", rd, 32'h5A);

    // BSR change mid-frame only affects the next frame
    fork
      send_frame(8'hC3, 9, 0);
      begin
        repeat (30) @(posedge clk_i);
        bus_write(2'd2, 32'd5);
      end
    join
    repeat (2) @(posedge clk_i);
    bus_read(2'd0, rd); check("bsr_old_rate_rdr", rd, 32'hC3);
    send_frame(8'h96, 18, 0);
    repeat (2) @(posedge clk_i);
    bus_read(2'd0, rd); check("bsr_new_rate_rdr", rd, 32'h96);
    bus_read(2'd2, rd); check("bsr_new_val", rd, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
